// File: rtl/mc_10101_pkg.sv
// Board-level ECL package shared by the mc10xxx gate models.
// Holds the flop reset levels used by the registered build of each part
// and a small helper for the OR function.
package mc_10101_pkg;

  // Level a registered true output takes while reset is asserted.
  localparam logic Q_RESET  = 1'b0;
  // Level a registered complement output takes while reset is asserted.
  localparam logic NQ_RESET = 1'b1;

  // 2-input OR as used by every gate of the quad.
  function automatic logic ecl_or2(input logic x, input logic y);
    return x | y;
  endfunction

endpackage

// File: rtl/mc_10101_if.sv
// Signal bundle for one MC10101 quad OR/NOR part.
// master: the driver of the gate inputs (board logic or a bench); it reads
//         the eight gate outputs.
// slave : the part itself; it reads the five inputs and drives the outputs.
// Signals: a1, b1, c1, d1 (private gate inputs), abcd2 (common input),
//          qa..qd (OR outputs), nqa..nqd (NOR outputs).
interface mc_10101_if;

  logic a1;
  logic b1;
  logic c1;
  logic d1;
  logic abcd2;
  logic qa;
  logic nqa;
  logic qb;
  logic nqb;
  logic qc;
  logic nqc;
  logic qd;
  logic nqd;

  modport master (
    output a1, b1, c1, d1, abcd2,
    input  qa, nqa, qb, nqb, qc, nqc, qd, nqd
  );

  modport slave (
    input  a1, b1, c1, d1, abcd2,
    output qa, nqa, qb, nqb, qc, nqc, qd, nqd
  );

endinterface

// File: rtl/mc_10101_gate.sv
// One 2-input OR/NOR gate of the MC10101 with an optional output flop.
// Ports:
//   clk    in  clock, only used when REGISTERED=1
//   reset  in  asynchronous active-high reset, only used when REGISTERED=1
//   in1    in  private gate input
//   in2    in  common gate input (abcd2 at the top level)
//   q      out in1 | in2 (registered when REGISTERED=1)
//   nq     out exact complement of q
module mc_10101_gate
  import mc_10101_pkg::*;
#(
  parameter bit REGISTERED = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in1,
  input  logic in2,
  output logic q,
  output logic nq
);

  logic or_val;

  assign or_val = ecl_or2(in1, in2);

  generate
    if (REGISTERED) begin : g_reg
      logic q_r;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          q_r <= Q_RESET;
        end else begin
          q_r <= or_val;
        end
      end

      assign q = q_r;
    end else begin : g_comb
      // The discrete part has no clock or reset; they are tied off here.
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset;
      assign q = or_val;
    end
  endgenerate

  // Complement is taken from q rather than from a second flop so the pair
  // can never disagree, including while reset is asserted.
  assign nq = ~q;

endmodule

// File: rtl/mc_10101.sv
// MC10101 ECL quad OR/NOR gate.
// Gate x (a, b, c, d) computes qx = x1 | abcd2 and nqx = ~qx.
// REGISTERED=0: purely combinational, clk and reset ignored.
// REGISTERED=1: each qx is captured on posedge clk; reset asynchronously
//               forces all qx=0 / nqx=1.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   a1, b1, c1, d1      private gate inputs
//   abcd2               input shared by all four gates
//   qa..qd / nqa..nqd   OR outputs and their complements
module mc_10101 #(
  parameter bit REGISTERED = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic a1,
  input  logic b1,
  input  logic c1,
  input  logic d1,
  input  logic abcd2,
  output logic qa,
  output logic nqa,
  output logic qb,
  output logic nqb,
  output logic qc,
  output logic nqc,
  output logic qd,
  output logic nqd
);

  mc_10101_gate #(.REGISTERED(REGISTERED)) u_gate_a (
    .clk   (clk),
    .reset (reset),
    .in1   (a1),
    .in2   (abcd2),
    .q     (qa),
    .nq    (nqa)
  );

  mc_10101_gate #(.REGISTERED(REGISTERED)) u_gate_b (
    .clk   (clk),
    .reset (reset),
    .in1   (b1),
    .in2   (abcd2),
    .q     (qb),
    .nq    (nqb)
  );

  mc_10101_gate #(.REGISTERED(REGISTERED)) u_gate_c (
    .clk   (clk),
    .reset (reset),
    .in1   (c1),
    .in2   (abcd2),
    .q     (qc),
    .nq    (nqc)
  );

  mc_10101_gate #(.REGISTERED(REGISTERED)) u_gate_d (
    .clk   (clk),
    .reset (reset),
    .in1   (d1),
    .in2   (abcd2),
    .q     (qd),
    .nq    (nqd)
  );

endmodule

// File: tb/tb_mc_10101.sv
// Directed bench for mc_10101: one combinational and one registered copy
// driven from the same input vectors {abcd2,d1,c1,b1,a1}.
module tb_mc_10101;

  logic clk;
  logic rst_c;
  logic rst_r;

  int unsigned n_cmp;
  int unsigned n_err;

  mc_10101_if ifc ();
  mc_10101_if ifr ();

  mc_10101 #(.REGISTERED(1'b0)) u_comb (
    .clk   (clk),
    .reset (rst_c),
    .a1    (ifc.a1),
    .b1    (ifc.b1),
    .c1    (ifc.c1),
    .d1    (ifc.d1),
    .abcd2 (ifc.abcd2),
    .qa    (ifc.qa),
    .nqa   (ifc.nqa),
    .qb    (ifc.qb),
    .nqb   (ifc.nqb),
    .qc    (ifc.qc),
    .nqc   (ifc.nqc),
    .qd    (ifc.qd),
    .nqd   (ifc.nqd)
  );

  mc_10101 #(.REGISTERED(1'b1)) u_reg (
    .clk   (clk),
    .reset (rst_r),
    .a1    (ifr.a1),
    .b1    (ifr.b1),
    .c1    (ifr.c1),
    .d1    (ifr.d1),
    .abcd2 (ifr.abcd2),
    .qa    (ifr.qa),
    .nqa   (ifr.nqa),
    .qb    (ifr.qb),
    .nqb   (ifr.nqb),
    .qc    (ifr.qc),
    .nqc   (ifr.nqc),
    .qd    (ifr.qd),
    .nqd   (ifr.nqd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // eq = expected {qd,qc,qb,qa}; complements are expected as ~eq.
  task automatic check_c(input string tag, input logic [3:0] eq);
    chk({tag, ".qa"},  ifc.qa,  eq[0]);
    chk({tag, ".nqa"}, ifc.nqa, ~eq[0]);
    chk({tag, ".qb"},  ifc.qb,  eq[1]);
    chk({tag, ".nqb"}, ifc.nqb, ~eq[1]);
    chk({tag, ".qc"},  ifc.qc,  eq[2]);
    chk({tag, ".nqc"}, ifc.nqc, ~eq[2]);
    chk({tag, ".qd"},  ifc.qd,  eq[3]);
    chk({tag, ".nqd"}, ifc.nqd, ~eq[3]);
  endtask

  task automatic check_r(input string tag, input logic [3:0] eq);
    chk({tag, ".qa"},  ifr.qa,  eq[0]);
    chk({tag, ".nqa"}, ifr.nqa, ~eq[0]);
    chk({tag, ".qb"},  ifr.qb,  eq[1]);
    chk({tag, ".nqb"}, ifr.nqb, ~eq[1]);
    chk({tag, ".qc"},  ifr.qc,  eq[2]);
    chk({tag, ".nqc"}, ifr.nqc, ~eq[2]);
    chk({tag, ".qd"},  ifr.qd,  eq[3]);
    chk({tag, ".nqd"}, ifr.nqd, ~eq[3]);
  endtask

  // v = {abcd2, d1, c1, b1, a1}, applied to both copies.
  task automatic set_in(input logic [4:0] v);
    {ifc.abcd2, ifc.d1, ifc.c1, ifc.b1, ifc.a1} = v;
    {ifr.abcd2, ifr.d1, ifr.c1, ifr.b1, ifr.a1} = v;
  endtask

  initial begin
    logic [4:0] v;
    logic [3:0] e;
    n_cmp = 0;
    n_err = 0;
    rst_c = 1'b0;
    rst_r = 1'b1;
    set_in(5'b00000);
    #1;
    check_r("reg_reset", 4'b0000);
    check_c("comb_init", 4'b0000);

    // Exhaustive sweep of the combinational copy; registered copy held in
    // reset while the clock runs.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      v = 5'(i);
      set_in(v);
      e = v[3:0] | {4{v[4]}};
      #1;
      check_c($sformatf("sweep%0d", i), e);
    end
    check_r("reg_held_sweep", 4'b0000);

    @(negedge clk);
    set_in(5'b00101);
    #1;
    check_c("example_00101", 4'b0101);

    // Common input dominance.
    set_in(5'b00000);
    #1;
    check_c("dom_lo", 4'b0000);
    set_in(5'b10000);
    #1;
    check_c("dom_hi", 4'b1111);
    set_in(5'b11111);
    #1;
    check_c("dom_all", 4'b1111);
    set_in(5'b00000);
    #1;
    check_c("dom_back", 4'b0000);

    // Reset has no effect on the combinational copy.
    rst_c = 1'b1;
    set_in(5'b00001);
    #1;
    check_c("comb_rst", 4'b0001);
    rst_c = 1'b0;
    #1;
    check_c("comb_rst_rel", 4'b0001);

    // Release registered reset; first edge loads current OR values.
    @(negedge clk);
    set_in(5'b00000);
    rst_r = 1'b0;
    #1;
    check_r("reg_rel", 4'b0000);
    @(posedge clk);
    #1;
    check_r("reg_first", 4'b0000);

    // One-cycle latency on gate B.
    @(negedge clk);
    set_in(5'b00010);
    #1;
    check_r("lat_before", 4'b0000);
    @(posedge clk);
    #1;
    check_r("lat_after", 4'b0010);

    // Mixed pattern through the flop.
    @(negedge clk);
    set_in(5'b01001);
    #1;
    check_r("mix_before", 4'b0010);
    @(posedge clk);
    #1;
    check_r("mix_after", 4'b1001);

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    set_in(5'b10000);
    @(posedge clk);
    #1;
    check_r("abcd2_reg", 4'b1111);
    #2;
    rst_r = 1'b1;
    #1;
    check_r("async_rst", 4'b0000);
    @(posedge clk);
    #1;
    check_r("rst_hold1", 4'b0000);
    @(posedge clk);
    #1;
    check_r("rst_hold2", 4'b0000);
    @(negedge clk);
    rst_r = 1'b0;
    #1;
    check_r("rst_rel_wait", 4'b0000);
    @(posedge clk);
    #1;
    check_r("rst_restore", 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
